// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared codes, control-field indices and FSM states for the EX stage
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_XOR = 3'b011;
    localparam logic [2:0] FN_MUL = 3'b100;
    localparam logic [2:0] FN_NOR = 3'b101;
    localparam logic [2:0] FN_SUB = 3'b110;
    localparam logic [2:0] FN_SLT = 3'b111;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

    localparam int EX_ALUSRC   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_REGDST   = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_seq_mult.sv
// rtl/ex_seq_mult.sv - iterative shift-add multiplier, one partial product per cycle
module ex_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Start,
    input  logic             In_Abort,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    output logic             Out_Done,
    output logic [WIDTH-1:0] Out_Product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;

    // Product includes the step taken this cycle so the result is ready on the final edge.
    assign acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign Out_Product = acc_step;
    assign Out_Done    = busy_q && (count_q == LAST);

    always_comb begin
        busy_d   = busy_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (In_Abort) begin
            busy_d = 1'b0;
        end else if (In_Start) begin
            busy_d   = 1'b1;
            count_d  = '0;
            mcand_d  = In_A;
            mplier_d = In_B;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (count_q == LAST) busy_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - MIPS EX stage: forwarding, ALU, multi-cycle MUL FSM, EX/MEM register
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                In_Valid,
    input  logic                In_Flush,
    input  logic [WIDTH-1:0]    In_DataA,
    input  logic [WIDTH-1:0]    In_DataB,
    input  logic [WIDTH-1:0]    In_SE,
    input  logic [REG_BITS-1:0] In_Rt,
    input  logic [REG_BITS-1:0] In_Rd,
    input  logic [3:0]          In_EXControl,
    input  logic [1:0]          In_MEMControl,
    input  logic [1:0]          In_WBControl,
    input  logic [2:0]          In_Funct,
    input  logic [1:0]          In_FwdA,
    input  logic [1:0]          In_FwdB,
    input  logic [WIDTH-1:0]    In_MemFwd,
    input  logic [WIDTH-1:0]    In_WbFwd,
    output logic                Out_Stall,
    output logic                Out_Valid,
    output logic [WIDTH-1:0]    Out_Result,
    output logic [WIDTH-1:0]    Out_Data,
    output logic [REG_BITS-1:0] Out_Rd,
    output logic [1:0]          Out_MEMControl,
    output logic [1:0]          Out_WBControl
);
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel, input logic [WIDTH-1:0] rf,
                                                 input logic [WIDTH-1:0] mem, input logic [WIDTH-1:0] wb);
        case (sel)
            FWD_MEM:              return mem;
            FWD_WB:               return wb;
            FWD_REG, FWD_REG_ALT: return rf;
            default:              return rf;
        endcase
    endfunction

    ex_state_e           state_q, state_d;
    logic [WIDTH-1:0]    fwd_a, fwd_b, op_b, alu_res, mul_prod;
    logic [REG_BITS-1:0] dst;
    logic [1:0]          alu_op;
    logic                slt, is_mul, mul_start, mul_abort, mul_done;

    logic [WIDTH-1:0]    lat_data_q, lat_data_d;
    logic [REG_BITS-1:0] lat_rd_q, lat_rd_d;
    logic [1:0]          lat_mem_q, lat_mem_d, lat_wb_q, lat_wb_d;

    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    result_q, result_d, data_q, data_d;
    logic [REG_BITS-1:0] rd_q, rd_d;
    logic [1:0]          mem_q, mem_d, wb_q, wb_d;

    assign fwd_a  = fwd_mux(In_FwdA, In_DataA, In_MemFwd, In_WbFwd);
    assign fwd_b  = fwd_mux(In_FwdB, In_DataB, In_MemFwd, In_WbFwd);
    assign op_b   = In_EXControl[EX_ALUSRC] ? In_SE : fwd_b;
    assign dst    = In_EXControl[EX_REGDST] ? In_Rd : In_Rt;
    assign alu_op = In_EXControl[EX_ALUOP_HI:EX_ALUOP_LO];
    assign slt    = $signed(fwd_a) < $signed(op_b);
    assign is_mul = (alu_op == ALUOP_FUNCT) && (In_Funct == FN_MUL);

    assign mul_start = (state_q == ST_IDLE) && In_Valid && !In_Flush && is_mul;
    assign mul_abort = (state_q == ST_MUL) && In_Flush;
    // On the final MUL cycle stall drops so upstream advances on the same edge the product lands.
    assign Out_Stall = mul_start || ((state_q == ST_MUL) && !In_Flush && !mul_done);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALUOP_ADD: alu_res = fwd_a + op_b;
            ALUOP_SUB: alu_res = fwd_a - op_b;
            ALUOP_SLT: alu_res = WIDTH'(slt);
            ALUOP_FUNCT: begin
                case (In_Funct)
                    FN_AND:  alu_res = fwd_a & op_b;
                    FN_OR:   alu_res = fwd_a | op_b;
                    FN_ADD:  alu_res = fwd_a + op_b;
                    FN_XOR:  alu_res = fwd_a ^ op_b;
                    FN_NOR:  alu_res = ~(fwd_a | op_b);
                    FN_SUB:  alu_res = fwd_a - op_b;
                    FN_SLT:  alu_res = WIDTH'(slt);
                    FN_MUL:  alu_res = '0;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    ex_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .In_Start    (mul_start),
        .In_Abort    (mul_abort),
        .In_A        (fwd_a),
        .In_B        (op_b),
        .Out_Done    (mul_done),
        .Out_Product (mul_prod)
    );

    always_comb begin
        state_d    = state_q;
        lat_data_d = lat_data_q;
        lat_rd_d   = lat_rd_q;
        lat_mem_d  = lat_mem_q;
        lat_wb_d   = lat_wb_q;
        valid_d    = 1'b0;
        result_d   = '0;
        data_d     = '0;
        rd_d       = '0;
        mem_d      = '0;
        wb_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (In_Valid && !In_Flush) begin
                    if (is_mul) begin
                        state_d    = ST_MUL;
                        lat_data_d = fwd_b;
                        lat_rd_d   = dst;
                        lat_mem_d  = In_MEMControl;
                        lat_wb_d   = In_WBControl;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        data_d   = fwd_b;
                        rd_d     = dst;
                        mem_d    = In_MEMControl;
                        wb_d     = In_WBControl;
                    end
                end
            end
            ST_MUL: begin
                if (In_Flush) begin
                    state_d = ST_IDLE;
                end else if (mul_done) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b1;
                    result_d = mul_prod;
                    data_d   = lat_data_q;
                    rd_d     = lat_rd_q;
                    mem_d    = lat_mem_q;
                    wb_d     = lat_wb_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            lat_data_q <= '0;
            lat_rd_q   <= '0;
            lat_mem_q  <= '0;
            lat_wb_q   <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            lat_data_q <= lat_data_d;
            lat_rd_q   <= lat_rd_d;
            lat_mem_q  <= lat_mem_d;
            lat_wb_q   <= lat_wb_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
        end
    end

    assign Out_Valid      = valid_q;
    assign Out_Result     = result_q;
    assign Out_Data       = data_q;
    assign Out_Rd         = rd_q;
    assign Out_MEMControl = mem_q;
    assign Out_WBControl  = wb_q;

endmodule
